uart_rx_byte: RTL and testbench

Receive front end of the FIFO summing design. Deserialises the 8N1 UART line `rx` into bytes for the row-summing stage downstream. Each valid byte is presented on `po_data` with a single-cycle `po_flag` strobe. Bad stop bits raise `frame_err` instead.

---
 rtl/uart_rx_byte_pkg.sv | 15 +
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx_byte.sv | 100 ++++++++++
 tb/tb_uart_rx_byte.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the UART receive front end: default line rates and
// the receiver state encoding (also used by the transmit stage).
package uart_rx_byte_pkg;

    localparam int DEFAULT_CLK_FREQ = 50_000_000;
    localparam int DEFAULT_UART_BPS = 115_200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Three-flop synchroniser for the asynchronous serial line, plus a
// falling-edge detect taken from the two settled stages.
module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic rx,
    output logic rx_sync,
    output logic rx_fall
);

    logic rx_s1;
    logic rx_s2;
    logic rx_s3;

    // Reset to the idle (high) level so release never looks like a start bit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_sync = rx_s2;
    assign rx_fall = rx_s3 & ~rx_s2;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: mid-bit sampling, one-cycle strobes for a good
// byte (po_flag) or a low stop bit (frame_err).
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int UART_BPS = DEFAULT_UART_BPS
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       frame_err
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int CNT_W        = $clog2(BAUD_CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_CNT_MAX / 2 - 1);

    rx_state_t        state;
    rx_state_t        state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             rx_sync;
    logic             rx_fall;
    logic             mid_bit;

    uart_rx_sync u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx        (rx),
        .rx_sync   (rx_sync),
        .rx_fall   (rx_fall)
    );

    assign mid_bit = (baud_cnt == CNT_MID);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Leaving STOP at mid-bit keeps half a bit of margin for a following start.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rx_fall) state_next = START;
            START:   if (mid_bit) state_next = rx_sync ? IDLE : DATA;
            DATA:    if (mid_bit && bit_cnt == 3'd7) state_next = STOP;
            STOP:    if (mid_bit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            po_data   <= '0;
            po_flag   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            po_flag   <= 1'b0;
            frame_err <= 1'b0;

            if (state == IDLE || baud_cnt == CNT_LAST) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (state == START && mid_bit) begin
                bit_cnt <= '0;
            end

            // Data arrives LSB first.
            if (state == DATA && mid_bit) begin
                shift[bit_cnt] <= rx_sync;
                bit_cnt        <= bit_cnt + 1'b1;
            end

            if (state == STOP && mid_bit) begin
                if (rx_sync) begin
                    po_data <= shift;
                    po_flag <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte at 16 clocks per bit; strobes are
// logged by a monitor and compared against bytes/timing computed from E0.
module tb_uart_rx_byte;

    localparam int N = 16;
    localparam int MID = N / 2 - 1;
    localparam int D = MID + 3 + 9 * N;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       rx;
    logic [7:0] po_data;
    logic       po_flag;
    logic       frame_err;

    int checks;
    int failures;
    int cyc;
    int overlap;
    logic [7:0] obs_data[$];
    int         obs_flag_cyc[$];
    int         obs_err_cyc[$];

    uart_rx_byte #(
        .CLK_FREQ (1_600_000),
        .UART_BPS (100_000)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx        (rx),
        .po_data   (po_data),
        .po_flag   (po_flag),
        .frame_err (frame_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Log every strobe with the index of the rising edge that produced it.
    always @(negedge sys_clk) begin
        if (po_flag) begin
            obs_data.push_back(po_data);
            obs_flag_cyc.push_back(cyc);
        end
        if (frame_err) obs_err_cyc.push_back(cyc);
        if (po_flag && frame_err) overlap++;
    end

    task automatic clear_obs();
        obs_data.delete();
        obs_flag_cyc.delete();
        obs_err_cyc.delete();
    endtask

    // Called at a negedge; returns at a negedge with rx left at the stop level.
    task automatic send_byte(input logic [7:0] d, input logic stop, output int e0);
        rx = 1'b0;
        e0 = cyc + 1;
        repeat (N) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (N) @(negedge sys_clk);
        end
        rx = stop;
        repeat (N) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (po_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_po_data: got %h expected 00", po_data);
        end
        checks++;
        if (po_flag !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_po_flag: got %b expected 0", po_flag);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err);
        end
        sys_rst_n = 1'b1;
        repeat (2 * N) @(negedge sys_clk);
    endtask

    task automatic test_single_byte();
        int e0;
        clear_obs();
        @(negedge sys_clk);
        send_byte(8'h55, 1'b1, e0);
        repeat (2 * N) @(negedge sys_clk);
        checks++;
        if (obs_data.size() !== 1) begin
            failures++;
            $display("[TB] FAIL single_count: got %0d strobes expected 1", obs_data.size());
        end
        if (obs_data.size() >= 1) begin
            checks++;
            if (obs_data[0] !== 8'h55) begin
                failures++;
                $display("[TB] FAIL single_data: got %h expected 55", obs_data[0]);
            end
            checks++;
            if (obs_flag_cyc[0] !== e0 + D) begin
                failures++;
                $display("[TB] FAIL single_time: got edge %0d expected %0d", obs_flag_cyc[0], e0 + D);
            end
        end
        checks++;
        if (obs_err_cyc.size() !== 0) begin
            failures++;
            $display("[TB] FAIL single_frame_err: got %0d expected 0", obs_err_cyc.size());
        end
        checks++;
        if (po_data !== 8'h55) begin
            failures++;
            $display("[TB] FAIL single_hold: got %h expected 55", po_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[3];
        int e0s[3];
        int n;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'hA5;
        clear_obs();
        @(negedge sys_clk);
        for (int i = 0; i < 3; i++) send_byte(bytes[i], 1'b1, e0s[i]);
        repeat (2 * N) @(negedge sys_clk);
        checks++;
        if (obs_data.size() !== 3) begin
            failures++;
            $display("[TB] FAIL b2b_count: got %0d expected 3", obs_data.size());
        end
        n = (obs_data.size() < 3) ? obs_data.size() : 3;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_data[i] !== bytes[i]) begin
                failures++;
                $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, obs_data[i], bytes[i]);
            end
            checks++;
            if (obs_flag_cyc[i] !== e0s[i] + D) begin
                failures++;
                $display("[TB] FAIL b2b_time%0d: got %0d expected %0d", i, obs_flag_cyc[i], e0s[i] + D);
            end
            if (i > 0) begin
                checks++;
                if (obs_flag_cyc[i] - obs_flag_cyc[i-1] !== 10 * N) begin
                    failures++;
                    $display("[TB] FAIL b2b_gap%0d: got %0d expected %0d", i,
                             obs_flag_cyc[i] - obs_flag_cyc[i-1], 10 * N);
                end
            end
        end
        checks++;
        if (obs_err_cyc.size() !== 0) begin
            failures++;
            $display("[TB] FAIL b2b_frame_err: got %0d expected 0", obs_err_cyc.size());
        end
    endtask

    task automatic test_start_glitch();
        int e0;
        clear_obs();
        @(negedge sys_clk);
        rx = 1'b0;
        repeat (4) @(negedge sys_clk);
        rx = 1'b1;
        repeat (3 * N) @(negedge sys_clk);
        checks++;
        if (obs_data.size() + obs_err_cyc.size() !== 0) begin
            failures++;
            $display("[TB] FAIL glitch_strobe: got %0d strobes expected 0", obs_data.size() + obs_err_cyc.size());
        end
        send_byte(8'h3C, 1'b1, e0);
        repeat (2 * N) @(negedge sys_clk);
        checks++;
        if (obs_data.size() !== 1) begin
            failures++;
            $display("[TB] FAIL glitch_after_count: got %0d expected 1", obs_data.size());
        end
        if (obs_data.size() >= 1) begin
            checks++;
            if (obs_data[0] !== 8'h3C || obs_flag_cyc[0] !== e0 + D) begin
                failures++;
                $display("[TB] FAIL glitch_after_byte: got %h@%0d expected 3c@%0d", obs_data[0], obs_flag_cyc[0], e0 + D);
            end
        end
    endtask

    task automatic test_frame_error();
        int e0a;
        int e0b;
        int e0c;
        clear_obs();
        @(negedge sys_clk);
        send_byte(8'h12, 1'b1, e0a);
        send_byte(8'hC3, 1'b0, e0b);
        // Line stays low after the bad stop bit: no retrigger expected.
        repeat (3 * N) @(negedge sys_clk);
        rx = 1'b1;
        repeat (2 * N) @(negedge sys_clk);
        checks++;
        if (po_data !== 8'h12) begin
            failures++;
            $display("[TB] FAIL ferr_hold: got %h expected 12", po_data);
        end
        send_byte(8'h5A, 1'b1, e0c);
        repeat (2 * N) @(negedge sys_clk);
        checks++;
        if (obs_err_cyc.size() !== 1) begin
            failures++;
            $display("[TB] FAIL ferr_count: got %0d expected 1", obs_err_cyc.size());
        end
        if (obs_err_cyc.size() >= 1) begin
            checks++;
            if (obs_err_cyc[0] !== e0b + D) begin
                failures++;
                $display("[TB] FAIL ferr_time: got %0d expected %0d", obs_err_cyc[0], e0b + D);
            end
        end
        checks++;
        if (obs_data.size() !== 2) begin
            failures++;
            $display("[TB] FAIL ferr_flag_count: got %0d expected 2", obs_data.size());
        end
        if (obs_data.size() >= 2) begin
            checks++;
            if (obs_data[0] !== 8'h12 || obs_data[1] !== 8'h5A) begin
                failures++;
                $display("[TB] FAIL ferr_data: got %h,%h expected 12,5a", obs_data[0], obs_data[1]);
            end
            checks++;
            if (obs_flag_cyc[1] !== e0c + D) begin
                failures++;
                $display("[TB] FAIL ferr_recover_time: got %0d expected %0d", obs_flag_cyc[1], e0c + D);
            end
        end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] d;
        int e0;
        d = 8'h7E;
        clear_obs();
        @(negedge sys_clk);
        rx = 1'b0;
        repeat (N) @(negedge sys_clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (N) @(negedge sys_clk);
        end
        rx = d[4];
        repeat (N / 2) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if (po_data !== 8'h00 || po_flag !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs: got %h/%b/%b expected 00/0/0", po_data, po_flag, frame_err);
        end
        @(negedge sys_clk);
        rx = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2 * N) @(negedge sys_clk);
        checks++;
        if (obs_data.size() + obs_err_cyc.size() !== 0) begin
            failures++;
            $display("[TB] FAIL midreset_strobe: got %0d expected 0", obs_data.size() + obs_err_cyc.size());
        end
        send_byte(8'h81, 1'b1, e0);
        repeat (2 * N) @(negedge sys_clk);
        checks++;
        if (obs_data.size() !== 1) begin
            failures++;
            $display("[TB] FAIL midreset_after_count: got %0d expected 1", obs_data.size());
        end
        if (obs_data.size() >= 1) begin
            checks++;
            if (obs_data[0] !== 8'h81 || obs_flag_cyc[0] !== e0 + D) begin
                failures++;
                $display("[TB] FAIL midreset_after_byte: got %h@%0d expected 81@%0d", obs_data[0], obs_flag_cyc[0], e0 + D);
            end
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] exp_data[$];
        int exp_cyc[$];
        logic [7:0] b;
        int e0;
        int n;
        clear_obs();
        @(negedge sys_clk);
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, N)) @(negedge sys_clk);
            b = 8'($urandom);
            send_byte(b, 1'b1, e0);
            exp_data.push_back(b);
            exp_cyc.push_back(e0 + D);
        end
        repeat (2 * N) @(negedge sys_clk);
        checks++;
        if (obs_data.size() !== exp_data.size()) begin
            failures++;
            $display("[TB] FAIL stream_count: got %0d expected %0d", obs_data.size(), exp_data.size());
        end
        n = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_data[i] !== exp_data[i] || obs_flag_cyc[i] !== exp_cyc[i]) begin
                failures++;
                $display("[TB] FAIL stream_byte%0d: got %h@%0d expected %h@%0d", i,
                         obs_data[i], obs_flag_cyc[i], exp_data[i], exp_cyc[i]);
            end
        end
        checks++;
        if (obs_err_cyc.size() !== 0) begin
            failures++;
            $display("[TB] FAIL stream_frame_err: got %0d expected 0", obs_err_cyc.size());
        end
        checks++;
        if (overlap !== 0) begin
            failures++;
            $display("[TB] FAIL strobe_overlap: got %0d expected 0", overlap);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        overlap = 0;
        sys_rst_n = 1'b0;
        rx = 1'b1;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_start_glitch();
        test_frame_error();
        test_reset_mid_byte();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
